mem_arbiter: RTL and testbench

//  Shares the single unified main-memory port between the I-cache miss

---
 rtl/mem_arbiter.sv | 164 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the single main-memory port between the I-cache fill
// handler and the D-cache miss handler (optional dirty writeback, then fill).
// Simultaneous requests alternate between the two requesters. Every output
// comes straight from a register.
module mem_arbiter #(
  parameter int ADDR_W = 14,
  parameter int LINE_W = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_rdy,
  output logic [LINE_W-1:0] i_rd_data,
  input  logic              d_req,
  input  logic              d_dirty,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [ADDR_W-1:0] d_wb_addr,
  input  logic [LINE_W-1:0] d_wb_data,
  output logic              d_rdy,
  output logic [LINE_W-1:0] d_rd_data,
  output logic              mem_re,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_wr_data,
  input  logic [LINE_W-1:0] mem_rd_data,
  input  logic              mem_rdy
);

  typedef enum logic [1:0] {IDLE, IRD, DWR, DRD} state_e;

  state_e              state_q, state_d;
  logic                lastGntIsD_q, lastGntIsD_d;
  logic                memRe_q, memRe_d;
  logic                memWe_q, memWe_d;
  logic [ADDR_W-1:0]   memAddr_q, memAddr_d;
  logic [LINE_W-1:0]   memWrData_q, memWrData_d;
  logic [ADDR_W-1:0]   fillAddr_q, fillAddr_d;
  logic                iRdy_q, iRdy_d;
  logic                dRdy_q, dRdy_d;
  logic [LINE_W-1:0]   iRdData_q, iRdData_d;
  logic [LINE_W-1:0]   dRdData_q, dRdData_d;
  logic                iElig, dElig, grantI, grantD;

  // A requester whose rdy is pulsing is still holding req this cycle, so it is
  // not eligible; on a tie, whoever did not win last time gets the port.
  always_comb begin
    iElig  = i_req & ~iRdy_q;
    dElig  = d_req & ~dRdy_q;
    grantI = iElig & (~dElig | lastGntIsD_q);
    grantD = dElig & (~iElig | ~lastGntIsD_q);
  end

  // Next-state and next-output logic; strobes, address and write data follow
  // the state and are updated on the same edge as it.
  always_comb begin
    state_d      = state_q;
    lastGntIsD_d = lastGntIsD_q;
    memRe_d      = memRe_q;
    memWe_d      = memWe_q;
    memAddr_d    = memAddr_q;
    memWrData_d  = memWrData_q;
    fillAddr_d   = fillAddr_q;
    iRdData_d    = iRdData_q;
    dRdData_d    = dRdData_q;
    iRdy_d       = 1'b0;
    dRdy_d       = 1'b0;
    case (state_q)
      IDLE: begin
        if (grantI) begin
          state_d      = IRD;
          lastGntIsD_d = 1'b0;
          memRe_d      = 1'b1;
          memAddr_d    = i_addr;
        end else if (grantD) begin
          lastGntIsD_d = 1'b1;
          fillAddr_d   = d_addr;
          if (d_dirty) begin
            state_d     = DWR;
            memWe_d     = 1'b1;
            memAddr_d   = d_wb_addr;
            memWrData_d = d_wb_data;
          end else begin
            state_d   = DRD;
            memRe_d   = 1'b1;
            memAddr_d = d_addr;
          end
        end
      end
      IRD: begin
        if (mem_rdy) begin
          state_d   = IDLE;
          memRe_d   = 1'b0;
          memAddr_d = '0;
          iRdData_d = mem_rd_data;
          iRdy_d    = 1'b1;
        end
      end
      DWR: begin
        if (mem_rdy) begin
          state_d     = DRD;
          memWe_d     = 1'b0;
          memWrData_d = '0;
          memRe_d     = 1'b1;
          memAddr_d   = fillAddr_q;
        end
      end
      DRD: begin
        if (mem_rdy) begin
          state_d   = IDLE;
          memRe_d   = 1'b0;
          memAddr_d = '0;
          dRdData_d = mem_rd_data;
          dRdy_d    = 1'b1;
        end
      end
      default: begin
        state_d   = IDLE;
        memRe_d   = 1'b0;
        memWe_d   = 1'b0;
        memAddr_d = '0;
      end
    endcase
  end

  // State and registered outputs; reset abandons any transaction in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      lastGntIsD_q <= 1'b1;
      memRe_q      <= 1'b0;
      memWe_q      <= 1'b0;
      memAddr_q    <= '0;
      memWrData_q  <= '0;
      fillAddr_q   <= '0;
      iRdy_q       <= 1'b0;
      dRdy_q       <= 1'b0;
      iRdData_q    <= '0;
      dRdData_q    <= '0;
    end else begin
      state_q      <= state_d;
      lastGntIsD_q <= lastGntIsD_d;
      memRe_q      <= memRe_d;
      memWe_q      <= memWe_d;
      memAddr_q    <= memAddr_d;
      memWrData_q  <= memWrData_d;
      fillAddr_q   <= fillAddr_d;
      iRdy_q       <= iRdy_d;
      dRdy_q       <= dRdy_d;
      iRdData_q    <= iRdData_d;
      dRdData_q    <= dRdData_d;
    end
  end

  assign i_rdy       = iRdy_q;
  assign i_rd_data   = iRdData_q;
  assign d_rdy       = dRdy_q;
  assign d_rd_data   = dRdData_q;
  assign mem_re      = memRe_q;
  assign mem_we      = memWe_q;
  assign mem_addr    = memAddr_q;
  assign mem_wr_data = memWrData_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed bench for mem_arbiter. The bench plays the memory,
// and expected fill data is queued when a transaction is set up and compared
// when the matching rdy pulse appears.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_req;
  logic [13:0] i_addr;
  logic        i_rdy;
  logic [63:0] i_rd_data;
  logic        d_req;
  logic        d_dirty;
  logic [13:0] d_addr;
  logic [13:0] d_wb_addr;
  logic [63:0] d_wb_data;
  logic        d_rdy;
  logic [63:0] d_rd_data;
  logic        mem_re;
  logic        mem_we;
  logic [13:0] mem_addr;
  logic [63:0] mem_wr_data;
  logic [63:0] mem_rd_data;
  logic        mem_rdy;

  int nAsserts = 0;
  int nFails   = 0;

  logic [63:0] iExp[$];
  logic [63:0] dExp[$];

  mem_arbiter #(.ADDR_W(14), .LINE_W(64)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_rdy(i_rdy), .i_rd_data(i_rd_data),
    .d_req(d_req), .d_dirty(d_dirty), .d_addr(d_addr), .d_wb_addr(d_wb_addr),
    .d_wb_data(d_wb_data), .d_rdy(d_rdy), .d_rd_data(d_rd_data),
    .mem_re(mem_re), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data), .mem_rdy(mem_rdy)
  );

  // 10 ns clock
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    nAsserts++;
    assert (observed === expected) else begin
      nFails++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic iReq, input logic dReq, input logic dDirty,
                               input logic [13:0] iAddr, input logic [13:0] dAddr,
                               input logic [13:0] dWbAddr, input logic [63:0] dWbData);
    i_req     = iReq;
    d_req     = dReq;
    d_dirty   = dDirty;
    i_addr    = iAddr;
    d_addr    = dAddr;
    d_wb_addr = dWbAddr;
    d_wb_data = dWbData;
  endtask

  task automatic waitStrobe(input bit isWrite, input string tag);
    for (int n = 0; n < 20; n++) begin
      if ((isWrite ? mem_we : mem_re) === 1'b1) break;
      tick();
    end
    checkOutput({tag, "_strobe"}, isWrite ? mem_we : mem_re, 64'd1);
  endtask

  // One memory access of 'latency' cycles, checked every cycle, mem_rdy in the last
  task automatic memAccess(input bit isWrite, input logic [13:0] expAddr,
                           input logic [63:0] expWr, input int latency,
                           input logic [63:0] rdData, input string tag);
    for (int k = 1; k <= latency; k++) begin
      checkOutput({tag, "_re"}, mem_re, {63'd0, !isWrite});
      checkOutput({tag, "_we"}, mem_we, {63'd0, isWrite});
      checkOutput({tag, "_addr"}, mem_addr, expAddr);
      if (isWrite) checkOutput({tag, "_wdata"}, mem_wr_data, expWr);
      if (k == latency) begin
        mem_rdy     = 1'b1;
        mem_rd_data = rdData;
      end
      tick();
    end
    mem_rdy     = 1'b0;
    mem_rd_data = 64'h0;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_mem_re"}, mem_re, 64'd0);
    checkOutput({tag, "_mem_we"}, mem_we, 64'd0);
    checkOutput({tag, "_mem_addr"}, mem_addr, 64'd0);
    checkOutput({tag, "_mem_wr_data"}, mem_wr_data, 64'd0);
    checkOutput({tag, "_i_rdy"}, i_rdy, 64'd0);
    checkOutput({tag, "_d_rdy"}, d_rdy, 64'd0);
    checkOutput({tag, "_i_rd_data"}, i_rd_data, 64'd0);
    checkOutput({tag, "_d_rd_data"}, d_rd_data, 64'd0);
  endtask

  // Scoreboard: every rdy pulse must match the oldest queued expectation
  always @(negedge clk) begin
    if (i_rdy === 1'b1) begin
      if (iExp.size() == 0) checkOutput("i_rdy_spurious", {63'd0, i_rdy}, 64'd0);
      else checkOutput("i_rd_data", i_rd_data, iExp.pop_front());
    end
    if (d_rdy === 1'b1) begin
      if (dExp.size() == 0) checkOutput("d_rdy_spurious", {63'd0, d_rdy}, 64'd0);
      else checkOutput("d_rd_data", d_rd_data, dExp.pop_front());
    end
  end

  // Hard stop in case the sequence itself wedges
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n       = 1'b0;
    mem_rdy     = 1'b0;
    mem_rd_data = 64'h0;
    applyStimulus(0, 0, 0, 14'h0, 14'h0, 14'h0, 64'h0);
    tick();
    tick();
    checkAllZero("reset");
    rst_n = 1'b1;

    // I-cache fill, 4-cycle memory
    $display("[TB] I-only fill");
    applyStimulus(1, 0, 0, 14'h0010, 14'h0, 14'h0, 64'h0);
    iExp.push_back(64'h1111_2222_3333_4444);
    waitStrobe(0, "ionly");
    memAccess(0, 14'h0010, 64'h0, 4, 64'h1111_2222_3333_4444, "ionly");
    checkOutput("ionly_i_rdy", i_rdy, 64'd1);
    checkOutput("ionly_re_drop", mem_re, 64'd0);
    tick();
    applyStimulus(0, 0, 0, 14'h0, 14'h0, 14'h0, 64'h0);
    checkOutput("ionly_i_rdy_pulse", i_rdy, 64'd0);
    checkOutput("ionly_no_regrant", mem_re, 64'd0);
    tick();

    // D-cache dirty miss: writeback then fill
    $display("[TB] D dirty miss");
    applyStimulus(0, 1, 1, 14'h0, 14'h0300, 14'h0200, 64'hAAAA_BBBB_CCCC_DDDD);
    dExp.push_back(64'h5555_6666_7777_8888);
    waitStrobe(1, "ddirty_wb");
    memAccess(1, 14'h0200, 64'hAAAA_BBBB_CCCC_DDDD, 3, 64'h0, "ddirty_wb");
    checkOutput("ddirty_handoff_re", mem_re, 64'd1);
    checkOutput("ddirty_handoff_we", mem_we, 64'd0);
    memAccess(0, 14'h0300, 64'h0, 2, 64'h5555_6666_7777_8888, "ddirty_fill");
    checkOutput("ddirty_d_rdy", d_rdy, 64'd1);
    tick();
    applyStimulus(0, 0, 0, 14'h0, 14'h0, 14'h0, 64'h0);
    checkOutput("ddirty_d_rdy_pulse", d_rdy, 64'd0);
    checkOutput("ddirty_no_regrant", mem_re, 64'd0);
    tick();

    // Reset in the middle of an I fill abandons it
    $display("[TB] reset mid-fill");
    applyStimulus(1, 0, 0, 14'h0040, 14'h0, 14'h0, 64'h0);
    waitStrobe(0, "rstmid");
    tick();
    tick();
    rst_n = 1'b0;
    applyStimulus(0, 0, 0, 14'h0, 14'h0, 14'h0, 64'h0);
    tick();
    tick();
    checkAllZero("rstmid");
    rst_n = 1'b1;
    tick();
    tick();
    checkOutput("rstmid_after_i_rdy", i_rdy, 64'd0);
    checkOutput("rstmid_after_re", mem_re, 64'd0);

    // Ties alternate, starting with I after reset
    for (int r = 0; r < 2; r++) begin
      logic [13:0] ia, da;
      logic [63:0] iv, dv;
      ia = 14'h0100 + 14'(r * 16);
      da = 14'h0180 + 14'(r * 16);
      iv = 64'h0101_0000_0000_0000 + 64'(r);
      dv = 64'h0D0D_0000_0000_0000 + 64'(r);
      $display("[TB] tie round %0d", r);
      applyStimulus(1, 1, 0, ia, da, 14'h0, 64'h0);
      iExp.push_back(iv);
      dExp.push_back(dv);
      waitStrobe(0, "tie_i");
      memAccess(0, ia, 64'h0, 2, iv, "tie_i");
      checkOutput("tie_i_rdy", i_rdy, 64'd1);
      tick();
      applyStimulus(0, 1, 0, 14'h0, da, 14'h0, 64'h0);
      memAccess(0, da, 64'h0, 2, dv, "tie_d");
      checkOutput("tie_d_rdy", d_rdy, 64'd1);
      tick();
      applyStimulus(0, 0, 0, 14'h0, 14'h0, 14'h0, 64'h0);
      tick();
    end

    // Requester inputs change mid-writeback; memory must see latched values
    $display("[TB] input change mid-writeback");
    applyStimulus(0, 1, 1, 14'h0, 14'h0123, 14'h0234, 64'hFEED_FACE_CAFE_BEEF);
    dExp.push_back(64'h9999_AAAA_BBBB_CCCC);
    waitStrobe(1, "chg_wb");
    applyStimulus(0, 1, 0, 14'h0, 14'h3FFF, 14'h3AAA, 64'h0BAD_0BAD_0BAD_0BAD);
    memAccess(1, 14'h0234, 64'hFEED_FACE_CAFE_BEEF, 3, 64'h0, "chg_wb");
    memAccess(0, 14'h0123, 64'h0, 2, 64'h9999_AAAA_BBBB_CCCC, "chg_fill");
    checkOutput("chg_d_rdy", d_rdy, 64'd1);
    tick();
    applyStimulus(0, 0, 0, 14'h0, 14'h0, 14'h0, 64'h0);
    tick();

    // Stray mem_rdy while idle changes nothing
    $display("[TB] stray mem_rdy in idle");
    mem_rdy     = 1'b1;
    mem_rd_data = 64'h1234_5678_9ABC_DEF0;
    tick();
    mem_rdy     = 1'b0;
    mem_rd_data = 64'h0;
    checkOutput("stray_re", mem_re, 64'd0);
    checkOutput("stray_we", mem_we, 64'd0);
    checkOutput("stray_i_rdy", i_rdy, 64'd0);
    checkOutput("stray_d_rdy", d_rdy, 64'd0);
    tick();
    checkOutput("stray_d_rdy_late", d_rdy, 64'd0);
    checkOutput("hold_d_rd_data", d_rd_data, 64'h9999_AAAA_BBBB_CCCC);
    checkOutput("hold_i_rd_data", i_rd_data, 64'h0101_0000_0000_0001);

    checkOutput("i_scoreboard_empty", 64'(iExp.size()), 64'd0);
    checkOutput("d_scoreboard_empty", 64'(dExp.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
    $finish;
  end

endmodule
